// File: rtl/uart_tx_engine.sv
// UART transmitter: FIFO-buffered serializer with optional parity, 1/2 stop bits and break.
// Ports: CLK, RST (sync, active-high); iDATA_BITS/iPARITY_EN/iODD_PARITY/iSTOP_BIT frame
//   format; iBREAK break request; iVALID/iDATA write port; oREADY, oFIFO_COUNT FIFO status;
//   oUART_TX_BUSY activity flag; oUART_TX registered serial line (idle high).
module uart_tx_engine #(
    parameter int OVER_SAMPLING = 4,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [3:0]                  iDATA_BITS,
    input  logic                        iPARITY_EN,
    input  logic                        iODD_PARITY,
    input  logic                        iSTOP_BIT,
    input  logic                        iBREAK,
    input  logic                        iVALID,
    input  logic [8:0]                  iDATA,
    output logic                        oREADY,
    output logic [$clog2(FIFO_DEPTH):0] oFIFO_COUNT,
    output logic                        oUART_TX_BUSY,
    output logic                        oUART_TX
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CYC_W = $clog2(OVER_SAMPLING);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(OVER_SAMPLING - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    // FIFO storage
    logic [8:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;

    // Frame engine
    state_t           state_q;
    logic [CYC_W-1:0] cyc_q;
    logic [3:0]       bit_q;
    logic [3:0]       nbits_q;
    logic             par_en_q;
    logic             par_q;
    logic             stop2_q;
    logic [8:0]       shift_q;
    logic             tx_q;
    logic             busy_q;

    logic [3:0]       nbits_c;
    logic [8:0]       head_c;
    logic             par_c;
    logic             bit_end;
    logic             frame_end;
    logic             line_c;

    assign oREADY        = (count_q < CNT_FULL);
    assign oFIFO_COUNT   = count_q;
    assign oUART_TX      = tx_q;
    assign oUART_TX_BUSY = busy_q;

    assign push = iVALID && oREADY;

    always_comb begin
        nbits_c = iDATA_BITS;
        if (iDATA_BITS < 4'd5) begin
            nbits_c = 4'd5;
        end else if (iDATA_BITS > 4'd9) begin
            nbits_c = 4'd9;
        end
    end

    // Head word with the unused upper bits cleared, so the parity and
    // shift register only ever see the active data bits.
    assign head_c = mem_q[rd_ptr_q] & (9'h1FF >> (4'd9 - nbits_c));
    assign par_c  = (^head_c) ^ iODD_PARITY;

    assign bit_end   = (cyc_q == CYC_LAST);
    assign frame_end = (state_q == ST_STOP) && bit_end &&
                       (bit_q == {3'b000, stop2_q});

    // Pop either from idle (break wins) or back-to-back at the last stop clock.
    assign pop = (count_q != '0) &&
                 (((state_q == ST_IDLE) && !iBREAK) || frame_end);

    // Line level for the current state; registered into tx_q next edge.
    always_comb begin
        line_c = 1'b1;
        unique case (state_q)
            ST_START:  line_c = 1'b0;
            ST_BREAK:  line_c = 1'b0;
            ST_DATA:   line_c = shift_q[0];
            ST_PARITY: line_c = par_q;
            default:   line_c = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            mem_q[wr_ptr_q] <= iDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cyc_q    <= '0;
            bit_q    <= '0;
            nbits_q  <= 4'd8;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            tx_q   <= line_c;
            busy_q <= (state_q != ST_IDLE) || (count_q != '0);
            cyc_q  <= bit_end ? '0 : cyc_q + CYC_W'(1);
            if (pop) begin
                // Frame format is frozen here for the whole frame.
                state_q  <= ST_START;
                cyc_q    <= '0;
                bit_q    <= '0;
                nbits_q  <= nbits_c;
                par_en_q <= iPARITY_EN;
                par_q    <= par_c;
                stop2_q  <= iSTOP_BIT;
                shift_q  <= head_c;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        cyc_q <= '0;
                        if (iBREAK) begin
                            state_q <= ST_BREAK;
                        end
                    end
                    ST_START: begin
                        if (bit_end) begin
                            state_q <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (bit_end) begin
                            shift_q <= shift_q >> 1;
                            if (bit_q == nbits_q - 4'd1) begin
                                bit_q   <= '0;
                                state_q <= par_en_q ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_q <= bit_q + 4'd1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (bit_end) begin
                            state_q <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (frame_end) begin
                            state_q <= ST_IDLE;
                        end else if (bit_end) begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end
                    ST_BREAK: begin
                        cyc_q <= '0;
                        // Release: one stop bit time of mark before anything else.
                        if (!iBREAK) begin
                            state_q <= ST_STOP;
                            bit_q   <= '0;
                            stop2_q <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
